mmio_bridge: RTL and testbench

Parametrised memory-mapped I/O bridge between the LC-3 datapath bus and external/test memory, superseding the fixed 4-digit Mem2IO path. It decodes each CPU request as either a memory access, run with a configurable wait-state count and SRAM-style active-low strobes, or an I/O access. I/O accesses are the switch read and writes/reads of a configurable number of 16-bit hex-display words. It sits between the datapath/ISDU and `test_memory`, and its nibble outputs feed the HexDriver instances.

---
 rtl/mmio_bridge.sv | 135 +++++++++++++
 tb/tb_mmio_bridge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - LC-3 memory-mapped I/O bridge with wait-stated SRAM path and hex display registers
//
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   req, we, addr, wdata  CPU request, sampled only while idle
//   rdata, ready, busy    read data (held), one-cycle completion pulse, not-idle flag
//   Switches              asynchronous board switches (2-flop synchronised)
//   mem_addr, mem_wdata   latched address / write data toward memory
//   mem_rdata             memory read data
//   mem_*_n               active-low SRAM strobes, asserted only in the MEM state
//   hex_nibbles           display words; word k at [k*DATA_W +: DATA_W]
module mmio_bridge #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 20,
   parameter int HEX_WORDS = 1,
   parameter int MEM_WAIT  = 2
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     req,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic                     ready,
   output logic                     busy,
   input  logic [DATA_W-1:0]        Switches,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     mem_ce_n,
   output logic                     mem_oe_n,
   output logic                     mem_we_n,
   output logic                     mem_ub_n,
   output logic                     mem_lb_n,
   output logic [HEX_WORDS*DATA_W-1:0] hex_nibbles
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MEM  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              lat_we;
   logic [DATA_W-1:0] sw_s1;
   logic [DATA_W-1:0] sw_s2;
   logic [DATA_W-1:0] hex [HEX_WORDS];

   // IO_TOP - addr equals ~addr in ADDR_W bits, so the bitwise inverse is the word index k.
   logic [ADDR_W-1:0] io_idx;
   logic              is_io;
   logic [DATA_W-1:0] io_rd;

   assign io_idx = ~addr;
   assign is_io  = (io_idx < ADDR_W'(HEX_WORDS));

   // Index 0 reads the switches; hex word 0 is write-only.
   always_comb begin
      io_rd = sw_s2;
      for (int i = 1; i < HEX_WORDS; i++) begin
         if (io_idx == ADDR_W'(i)) io_rd = hex[i];
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= Switches;
         sw_s2 <= sw_s1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         for (int i = 0; i < HEX_WORDS; i++) hex[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  lat_we    <= we;
                  mem_addr  <= addr;
                  mem_wdata <= wdata;
                  if (is_io) begin
                     if (we) begin
                        for (int i = 0; i < HEX_WORDS; i++) begin
                           if (io_idx == ADDR_W'(i)) hex[i] <= wdata;
                        end
                     end else begin
                        rdata <= io_rd;
                     end
                     state <= DONE;
                  end else begin
                     cnt   <= CNT_W'(MEM_WAIT - 1);
                     state <= MEM;
                  end
               end
            end
            MEM: begin
               if (cnt == '0) begin
                  if (!lat_we) rdata <= mem_rdata;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes decode straight from state so an asynchronous reset drops them at once.
   assign ready    = (state == DONE);
   assign busy     = (state != IDLE);
   assign mem_ce_n = (state != MEM);
   assign mem_ub_n = (state != MEM);
   assign mem_lb_n = (state != MEM);
   assign mem_oe_n = !((state == MEM) && !lat_we);
   assign mem_we_n = !((state == MEM) && lat_we);

   for (genvar g = 0; g < HEX_WORDS; g++) begin : g_hex
      assign hex_nibbles[g*DATA_W +: DATA_W] = hex[g];
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - self-checking bench for mmio_bridge (HEX_WORDS=2, MEM_WAIT=3)
module tb_mmio_bridge;

   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 20;
   localparam int HEX_WORDS = 2;
   localparam int MEM_WAIT  = 3;

   logic              Clk = 1'b0;
   logic              Reset = 1'b1;
   logic              req = 1'b0;
   logic              we = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic [DATA_W-1:0] Switches = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;
   logic [HEX_WORDS*DATA_W-1:0] hex_nibbles;

   int tests = 0;
   int fails = 0;

   mmio_bridge #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .HEX_WORDS(HEX_WORDS), .MEM_WAIT(MEM_WAIT)
   ) dut (
      .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .busy(busy), .Switches(Switches),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
      .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n), .hex_nibbles(hex_nibbles)
   );

   always #5 Clk = ~Clk;

   // Presents a request on a falling edge; the next rising edge is edge 0.
   task automatic start_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      @(negedge Clk);
      req = 1'b1; we = w; addr = a; wdata = d;
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata got %h want 0000", rdata); end
      tests++; if (hex_nibbles !== 32'h0) begin fails++; $display("FAIL reset_hex got %h want 0", hex_nibbles); end
      tests++; if (mem_addr !== 20'h0 || mem_wdata !== 16'h0) begin fails++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
      tests++; if ({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n} !== 5'b11111) begin fails++;
         $display("FAIL reset_strobes got %b want 11111", {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}); end
      // Request raised while reset is still high must not be taken before the first clean edge.
      req = 1'b1; we = 1'b1; addr = 20'hFFFFF; wdata = 16'h7777;
      @(negedge Clk);
      tests++; if (hex_nibbles !== 32'h0 || busy !== 1'b0) begin fails++; $display("FAIL reset_req_ignored got hex %h busy %b want 0/0", hex_nibbles, busy); end
      req = 1'b0;
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_hex_write;
      int rdy;
      int strobes;
      rdy = 0; strobes = 0;
      start_req(1'b1, 20'hFFFFE, 16'hBEEF);
      for (int c = 1; c <= 3; c++) begin
         @(negedge Clk);
         if (c == 1) begin
            req = 1'b0;
            tests++; if (hex_nibbles[31:16] !== 16'hBEEF) begin fails++; $display("FAIL hex1_word1 got %h want BEEF", hex_nibbles[31:16]); end
            tests++; if (ready !== 1'b1) begin fails++; $display("FAIL hex1_ready_c1 got %b want 1", ready); end
         end
         if (ready === 1'b1) rdy++;
         if (mem_ce_n !== 1'b1 || mem_we_n !== 1'b1 || mem_oe_n !== 1'b1) strobes++;
      end
      tests++; if (rdy != 1) begin fails++; $display("FAIL hex1_ready_pulses got %0d want 1", rdy); end
      tests++; if (strobes != 0) begin fails++; $display("FAIL hex1_strobes got %0d want 0", strobes); end
      tests++; if (hex_nibbles[15:0] !== 16'h0) begin fails++; $display("FAIL hex1_word0 got %h want 0000", hex_nibbles[15:0]); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hex1_idle got busy %b want 0", busy); end
      // Write to IO_TOP lands in word 0.
      start_req(1'b1, 20'hFFFFF, 16'h1357);
      @(negedge Clk); req = 1'b0;
      tests++; if (hex_nibbles !== 32'hBEEF_1357) begin fails++; $display("FAIL hex0_write got %h want BEEF1357", hex_nibbles); end
      @(negedge Clk);
      // Read back word 1.
      start_req(1'b0, 20'hFFFFE, 16'h0);
      @(negedge Clk); req = 1'b0;
      tests++; if (rdata !== 16'hBEEF || ready !== 1'b1) begin fails++; $display("FAIL hex1_read got %h rdy %b want BEEF/1", rdata, ready); end
      @(negedge Clk);
   endtask

   task automatic test_mem_write;
      logic exp_act;
      start_req(1'b1, 20'h00040, 16'h1234);
      for (int c = 1; c <= 6; c++) begin
         @(negedge Clk);
         if (c == 1) req = 1'b0;
         exp_act = (c >= 1 && c <= 3);
         tests++; if (mem_we_n !== !exp_act || mem_ce_n !== !exp_act || mem_oe_n !== 1'b1) begin fails++;
            $display("FAIL memw_strobes c%0d got we%b ce%b oe%b want we%b ce%b oe1", c, mem_we_n, mem_ce_n, mem_oe_n, !exp_act, !exp_act); end
         tests++; if (ready !== (c == 4)) begin fails++; $display("FAIL memw_ready c%0d got %b want %b", c, ready, (c == 4)); end
      end
      tests++; if (mem_addr !== 20'h00040 || mem_wdata !== 16'h1234) begin fails++; $display("FAIL memw_bus got %h/%h want 00040/1234", mem_addr, mem_wdata); end
      tests++; if (hex_nibbles !== 32'hBEEF_1357) begin fails++; $display("FAIL memw_hex_untouched got %h want BEEF1357", hex_nibbles); end
   endtask

   task automatic test_mem_read;
      mem_rdata = 16'h1234;
      start_req(1'b0, 20'h00040, 16'h0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge Clk);
         if (c == 1) req = 1'b0;
         if (c == 5) mem_rdata = 16'hDEAD;
         tests++; if (mem_oe_n !== !(c <= 3) || mem_we_n !== 1'b1) begin fails++;
            $display("FAIL memr_strobes c%0d got oe%b we%b want oe%b we1", c, mem_oe_n, mem_we_n, !(c <= 3)); end
         if (c == 4) begin
            tests++; if (ready !== 1'b1 || rdata !== 16'h1234) begin fails++; $display("FAIL memr_data got %h rdy %b want 1234/1", rdata, ready); end
         end
      end
      tests++; if (rdata !== 16'h1234) begin fails++; $display("FAIL memr_hold got %h want 1234", rdata); end
   endtask

   task automatic test_switches;
      Switches = 16'h00FF;
      repeat (3) @(negedge Clk);
      start_req(1'b0, 20'hFFFFF, 16'h0);
      @(negedge Clk); req = 1'b0;
      tests++; if (rdata !== 16'h00FF || ready !== 1'b1) begin fails++; $display("FAIL sw_read1 got %h rdy %b want 00FF/1", rdata, ready); end
      @(negedge Clk);
      Switches = 16'hA5A5;
      start_req(1'b0, 20'hFFFFF, 16'h0);
      @(negedge Clk); req = 1'b0;
      tests++; if (rdata !== 16'h00FF) begin fails++; $display("FAIL sw_read_early got %h want 00FF", rdata); end
      @(negedge Clk);
      start_req(1'b0, 20'hFFFFF, 16'h0);
      @(negedge Clk); req = 1'b0;
      tests++; if (rdata !== 16'hA5A5) begin fails++; $display("FAIL sw_read_late got %h want A5A5", rdata); end
      @(negedge Clk);
   endtask

   task automatic test_reset_mid;
      int rdy;
      rdy = 0;
      mem_rdata = 16'h4321;
      start_req(1'b0, 20'h00040, 16'h0);
      @(negedge Clk); req = 1'b0;
      @(negedge Clk);
      tests++; if (mem_ce_n !== 1'b0 || mem_oe_n !== 1'b0) begin fails++; $display("FAIL rmid_active got ce%b oe%b want 0/0", mem_ce_n, mem_oe_n); end
      #1 Reset = 1'b1;
      #1;
      tests++; if ({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n} !== 5'b11111 || busy !== 1'b0) begin fails++;
         $display("FAIL rmid_async got %b busy %b want 11111/0", {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, busy); end
      tests++; if (hex_nibbles !== 32'h0) begin fails++; $display("FAIL rmid_hex got %h want 0", hex_nibbles); end
      @(negedge Clk); Reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         if (ready === 1'b1) rdy++;
      end
      tests++; if (rdy != 0) begin fails++; $display("FAIL rmid_no_ready got %0d want 0", rdy); end
      mem_rdata = 16'h5555;
      start_req(1'b0, 20'h00123, 16'h0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge Clk);
         if (c == 1) req = 1'b0;
      end
      tests++; if (ready !== 1'b1 || rdata !== 16'h5555) begin fails++; $display("FAIL rmid_next got %h rdy %b want 5555/1", rdata, ready); end
      @(negedge Clk);
   endtask

   task automatic test_back_to_back;
      int n;
      int first;
      int second;
      n = 0; first = -1; second = -1;
      mem_rdata = 16'h0F0F;
      start_req(1'b0, 20'h00200, 16'h0);
      for (int c = 1; c <= 12; c++) begin
         @(negedge Clk);
         if (ready === 1'b1) begin
            n++;
            if (first < 0) first = c; else if (second < 0) second = c;
         end
         if (c == 9) req = 1'b0;
      end
      tests++; if (n != 2) begin fails++; $display("FAIL b2b_count got %0d want 2", n); end
      tests++; if (first != 4) begin fails++; $display("FAIL b2b_first got %0d want 4", first); end
      tests++; if (second - first != MEM_WAIT + 2) begin fails++; $display("FAIL b2b_gap got %0d want %0d", second - first, MEM_WAIT + 2); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got busy %b want 0", busy); end
   endtask

   initial begin
      test_reset;
      test_hex_write;
      test_mem_write;
      test_mem_read;
      test_switches;
      test_reset_mid;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
